// File: rtl/gpu_pkg.sv
// gpu_pkg: shared lane count, default lane width, lane vector type and
// memory-sequencer FSM states.
package gpu_pkg;
    localparam int LANES = 3;
    localparam int N_DEF = 18;
    typedef logic [LANES-1:0][N_DEF-1:0] lane_vec_t;
    typedef enum logic [2:0] {IDLE, ACC0, ACC1, ACC2, DRAIN} seq_state_t;
endpackage

// File: rtl/mem_lane_sequencer.sv
// mem_lane_sequencer: serialises a 3-lane EX/MEM op onto one synchronous memory port.
// Optional MEM_SEQ_ADDR_CHECK_EN suppresses out-of-range lane accesses and reports addr_err.
module mem_lane_sequencer
    import gpu_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int MEM_AW = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  stall,
    input  logic [LANES-1:0][N-1:0] alu_result,
    input  logic [LANES-1:0][N-1:0] write_data,
    input  logic                  RegWrite,
    input  logic                  MemtoReg,
    input  logic                  MemWrite,
    input  logic [3:0]            WA3,
    output logic [N-1:0]          mem_addr,
    output logic [N-1:0]          mem_wdata,
    output logic                  mem_we,
    input  logic [N-1:0]          mem_rdata,
    output logic                  out_valid,
    output logic [LANES-1:0][N-1:0] read_data,
    output logic [LANES-1:0][N-1:0] alu_result_o,
    output logic                  RegWriteO,
    output logic                  MemtoRegO,
    output logic [3:0]            WA3O
`ifdef MEM_SEQ_ADDR_CHECK_EN
    ,
    output logic                  addr_err
`endif
);
    if (MEM_AW > N) begin : g_aw_check
        $error("MEM_AW must not exceed N");
    end

    seq_state_t state, state_n;
    logic [LANES-1:0][N-1:0] cap_addr, cap_wdata;
    logic [1:0][N-1:0] rd_buf;
    logic cap_we, cap_mtr, cap_rw;
    logic [3:0] cap_wa3;
    logic accept, mem_op, in_acc;
    logic [1:0] lane;
    logic [LANES-1:0] lane_ok;

    assign stall  = state != IDLE;
    assign accept = in_valid && !stall && !reset;
    assign mem_op = MemWrite | MemtoReg;

`ifdef MEM_SEQ_ADDR_CHECK_EN
    always_comb begin
        for (int i = 0; i < LANES; i++) lane_ok[i] = (cap_addr[i] >> MEM_AW) == '0;
    end
`else
    assign lane_ok = '1;
`endif

    always_comb begin
        in_acc    = state inside {ACC0, ACC1, ACC2};
        lane      = state == ACC0 ? 2'd0 : state == ACC1 ? 2'd1 : 2'd2;
        mem_addr  = in_acc ? cap_addr[lane] : '0;
        mem_wdata = in_acc ? cap_wdata[lane] : '0;
        mem_we    = in_acc && cap_we && lane_ok[lane];
        state_n   = state == IDLE  ? (accept && mem_op ? ACC0 : IDLE) :
                    state == DRAIN ? IDLE : seq_state_t'(state + 3'd1);
    end

    // Lane i's read data arrives one cycle after ACCi, i.e. while in the following state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            out_valid    <= 1'b0;
            read_data    <= '0;
            alu_result_o <= '0;
            RegWriteO    <= 1'b0;
            MemtoRegO    <= 1'b0;
            WA3O         <= '0;
`ifdef MEM_SEQ_ADDR_CHECK_EN
            addr_err     <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            out_valid <= 1'b0;
            if (accept) begin
                cap_addr  <= alu_result;
                cap_wdata <= write_data;
                cap_we    <= MemWrite;
                cap_mtr   <= MemtoReg;
                cap_rw    <= RegWrite;
                cap_wa3   <= WA3;
            end
            if (state == ACC1) rd_buf[0] <= cap_mtr && lane_ok[0] ? mem_rdata : '0;
            if (state == ACC2) rd_buf[1] <= cap_mtr && lane_ok[1] ? mem_rdata : '0;
            if (accept && !mem_op) begin
                out_valid    <= 1'b1;
                read_data    <= '0;
                alu_result_o <= alu_result;
                RegWriteO    <= RegWrite;
                MemtoRegO    <= MemtoReg;
                WA3O         <= WA3;
`ifdef MEM_SEQ_ADDR_CHECK_EN
                addr_err     <= 1'b0;
`endif
            end else if (state == DRAIN) begin
                out_valid    <= 1'b1;
                read_data    <= {cap_mtr && lane_ok[2] ? mem_rdata : '0, rd_buf[1], rd_buf[0]};
                alu_result_o <= cap_addr;
                RegWriteO    <= cap_rw;
                MemtoRegO    <= cap_mtr;
                WA3O         <= cap_wa3;
`ifdef MEM_SEQ_ADDR_CHECK_EN
                addr_err     <= ~&lane_ok;
`endif
            end
        end
    end
endmodule
